// File: rtl/binary_quiz_game.sv
// Binary quiz game: shows a random 4-bit add/sub problem and grades the player's 5-bit answer.
// Keeps score over a fixed-length round and shows correct/wrong feedback.
module binary_quiz_game #(
    parameter logic [7:0] SEED            = 8'hA5,
    parameter int         FEEDBACK_CYCLES = 25_000_000,
    parameter int         NUM_QUESTIONS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn_pulse,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [63:0] grid,
    output logic        check_ok,
    output logic [7:0]  score
);

    localparam logic [7:0]      SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam int              FB_W     = (FEEDBACK_CYCLES > 1) ? $clog2(FEEDBACK_CYCLES) : 1;
    localparam logic [FB_W-1:0] FB_LOAD  = FB_W'(FEEDBACK_CYCLES - 1);
    localparam logic [FB_W-1:0] FB_ONE   = FB_W'(1);
    localparam logic [3:0]      LAST_Q   = 4'(NUM_QUESTIONS - 1);
    localparam logic [3:0]      NQ4      = 4'(NUM_QUESTIONS);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_ASK      = 3'd2,
        ST_FEEDBACK = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Subtraction answer carries the borrow in bit 4 above the 4-bit difference.
    function automatic logic [4:0] expected_answer(input logic [3:0] a, input logic [3:0] b,
                                                   input logic is_sub);
        logic [3:0] diff;
        diff = a - b;
        if (is_sub) begin
            expected_answer = {(a < b), diff};
        end else begin
            expected_answer = {1'b0, a} + {1'b0, b};
        end
    endfunction

    state_t          state_r, state_s;
    logic [7:0]      lfsr_r, lfsr_s;
    logic [3:0]      op_a_r, op_a_s, op_b_r, op_b_s;
    logic            op_r, op_s;
    logic [3:0]      q_idx_r, q_idx_s;
    logic [7:0]      score_r, score_s;
    logic            check_ok_r, check_ok_s;
    logic [FB_W-1:0] fb_cnt_r, fb_cnt_s;
    logic            start_s, submit_s, correct_s;
    logic [15:0]     led_s;
    logic [63:0]     grid_s;
    logic            unused_s;

    assign start_s  = btn_pulse[1];
    assign submit_s = btn_pulse[0];
    assign unused_s = ^{btn_pulse[4:2], sw[15:11], sw[9:7], sw[1:0]};

    // Next-state and datapath: start pre-empts everything, including a same-cycle submit.
    always_comb begin
        state_s    = state_r;
        lfsr_s     = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        op_a_s     = op_a_r;
        op_b_s     = op_b_r;
        op_s       = op_r;
        q_idx_s    = q_idx_r;
        score_s    = score_r;
        check_ok_s = check_ok_r;
        fb_cnt_s   = fb_cnt_r;
        correct_s  = (sw[6:2] == expected_answer(op_a_r, op_b_r, op_r));
        if (start_s) begin
            state_s    = ST_LOAD;
            q_idx_s    = 4'd0;
            score_s    = 8'd0;
            check_ok_s = 1'b0;
            fb_cnt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    op_a_s  = lfsr_r[3:0];
                    op_b_s  = lfsr_r[7:4];
                    op_s    = sw[10];
                    state_s = ST_ASK;
                end
                ST_ASK: begin
                    if (submit_s) begin
                        check_ok_s = correct_s;
                        if (correct_s && (score_r != 8'hFF)) begin
                            score_s = score_r + 8'd1;
                        end else begin
                            score_s = score_r;
                        end
                        fb_cnt_s = FB_LOAD;
                        state_s  = ST_FEEDBACK;
                    end else begin
                        state_s = ST_ASK;
                    end
                end
                ST_FEEDBACK: begin
                    if (fb_cnt_r == '0) begin
                        if (q_idx_r == LAST_Q) begin
                            state_s = ST_DONE;
                        end else begin
                            q_idx_s = q_idx_r + 4'd1;
                            state_s = ST_LOAD;
                        end
                    end else begin
                        fb_cnt_s = fb_cnt_r - FB_ONE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            lfsr_r     <= SEED_EFF;
            op_a_r     <= 4'd0;
            op_b_r     <= 4'd0;
            op_r       <= 1'b0;
            q_idx_r    <= 4'd0;
            score_r    <= 8'd0;
            check_ok_r <= 1'b0;
            fb_cnt_r   <= '0;
        end else begin
            state_r    <= state_s;
            lfsr_r     <= lfsr_s;
            op_a_r     <= op_a_s;
            op_b_r     <= op_b_s;
            op_r       <= op_s;
            q_idx_r    <= q_idx_s;
            score_r    <= score_s;
            check_ok_r <= check_ok_s;
            fb_cnt_r   <= fb_cnt_s;
        end
    end

    // LED and grid decode from registered state; only the ASK answer row follows live switches.
    always_comb begin
        led_s  = 16'h0000;
        grid_s = 64'h0;
        case (state_r)
            ST_IDLE: begin
                led_s = 16'h0000;
            end
            ST_LOAD: begin
                led_s[12:0] = {q_idx_r, op_r, op_b_r, op_a_r};
            end
            ST_ASK: begin
                led_s[12:0]   = {q_idx_r, op_r, op_b_r, op_a_r};
                grid_s[3:0]   = op_a_r;
                grid_s[11:8]  = op_b_r;
                grid_s[16]    = op_r;
                grid_s[60:56] = sw[6:2];
            end
            ST_FEEDBACK: begin
                led_s[12:0] = {q_idx_r, op_r, op_b_r, op_a_r};
                led_s[13]   = check_ok_r;
                led_s[14]   = !check_ok_r;
                grid_s      = check_ok_r ? {64{1'b1}} : 64'hAA55_AA55_AA55_AA55;
            end
            ST_DONE: begin
                led_s[12:0]   = {q_idx_r, op_r, op_b_r, op_a_r};
                led_s[15]     = 1'b1;
                grid_s[7:0]   = score_r;
                grid_s[59:56] = NQ4;
            end
            default: begin
                led_s = 16'h0000;
            end
        endcase
    end

    assign led      = led_s;
    assign grid     = grid_s;
    assign check_ok = check_ok_r;
    assign score    = score_r;

endmodule

// File: doc/binary_quiz_game.md
Name: binary_quiz_game

Overview:
- Inverse companion to the binary adder game. The block generates a 4-bit A/B problem, shows the operands on the LEDs and grid, and reads the player's binary answer from the switches.
- On submit it grades the answer, shows feedback, keeps score, and runs a fixed-length round.
- Sits beside the other games under the top-level game mux and uses the same game-slot interface.

Parameters:
- SEED, 8'hA5, LFSR reset value. A value of 0 is replaced by 8'h01.
- FEEDBACK_CYCLES, 25_000_000, number of cycles feedback is held. Must be ≥1.
- NUM_QUESTIONS, 10, questions per round. Range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- btn_pulse  in  5  one-cycle button pulses; [0]=submit, [1]=start; [4:2] ignored
- sw  in  16  [6:2]=answer (5-bit), [10]=op select (0 add, 1 sub); [1:0] top-level game select, ignored; others ignored
- led  out  16  status (see Behaviour)
- grid  out  64  8x8 display, bit r*8+c
- check_ok  out  1  last submitted answer was correct
- score  out  8  correct answers this round

Behaviour:
- Reset (rst=0, async): state=IDLE, lfsr=SEED, op_a=op_b=0, op=0, q_idx=0, score=0, check_ok=0, fb_cnt=0. All outputs are registered or derived from registers, so led=0 and grid=0 during reset.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1). Steps every clock in every state. Never reaches 0.
- FSM states: IDLE, LOAD, ASK, FEEDBACK, DONE.
- IDLE: wait for start; start -> LOAD, with q_idx=0, score=0, check_ok=0.
- LOAD (1 cycle): op_a<=lfsr[3:0], op_b<=lfsr[7:4], op<=sw[10]; -> ASK.
- ASK: on submit, compute expected (5 bits):
  - add: {1'b0,op_a}+{1'b0,op_b}
  - sub: {borrow, (op_a-op_b)[3:0]}, where borrow=(op_a<op_b)
  - correct = (sw[6:2]==expected).
  - Next cycle: check_ok=correct; score+=correct, saturating at 255; fb_cnt=FEEDBACK_CYCLES-1; -> FEEDBACK. Latency from the submit sample to the outputs is 1 cycle.
- FEEDBACK: decrement fb_cnt. At fb_cnt==0:
  - if q_idx==NUM_QUESTIONS-1 -> DONE;
  - else q_idx++ and -> LOAD.
- DONE: hold score and check_ok. Start -> LOAD with q_idx=0, score=0, check_ok=0.
- Start in ASK/FEEDBACK/DONE: restarts the round exactly as from IDLE, dropping any in-progress feedback.
- Start and submit in the same cycle: start wins; submit is dropped.
- Submit outside ASK is ignored. Answer switches are sampled only in the submit cycle.
- sw[10] is sampled only in LOAD. Changing it mid-question has no effect.
- led mapping:
  - [3:0]=op_a, [7:4]=op_b, [8]=op
  - [12:9]=q_idx
  - [13]=1 in FEEDBACK and check_ok
  - [14]=1 in FEEDBACK and !check_ok
  - [15]=1 in DONE
  - In IDLE, led=0.
- grid mapping:
  - ASK: row0 cols[3:0]=op_a, row1 cols[3:0]=op_b, row2 col0=op, row7 cols[4:0]=live sw[6:2]. All else 0.
  - FEEDBACK: correct -> all 64 bits 1; wrong -> 64'hAA55_AA55_AA55_AA55.
  - DONE: row0 = score[7:0], row7 cols[3:0] = NUM_QUESTIONS.
  - IDLE/LOAD: 0.
- Reset mid-round: immediate return to the reset values. No residual feedback.

Test Plan:
- Reset, then start with FEEDBACK_CYCLES=4: LOAD then ASK. Bench reads led[7:0] (e.g. op_a=5, op_b=10, op=0) and drives sw[6:2]=15 + submit -> next cycle check_ok=1, score=1, led[13]=1, grid=all ones. After 4 cycles -> LOAD, q_idx=1.
- Sub with op_a=3, op_b=9: answer {1,4'hA}=5'h1A -> correct. Answer 5'h0A -> check_ok=0, score unchanged, led[14]=1, grid=64'hAA55_AA55_AA55_AA55.
- Add with op_a=15, op_b=15: answer 5'h1E -> correct; carry handled.
- NUM_QUESTIONS=3, all correct: after the third feedback -> DONE, led[15]=1, score=3, grid row0=8'h03. Further submit ignored. Start -> score=0, q_idx=0.
- Start and submit in the same ASK cycle -> round restarts, score=0, no grading. Submit during FEEDBACK -> ignored, fb_cnt unaffected.
- rst low mid-FEEDBACK (asynchronous, between edges) -> led=0, grid=0, score=0, check_ok=0 immediately. After release, LFSR restarts from SEED; a zero SEED yields first lfsr=8'h01.
